// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cache_ctrl_pkg : shared defaults and FSM encoding for cache_ctrl |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package cache_ctrl_pkg;
    localparam int c_AW      = 8;
    localparam int c_DW      = 8;
    localparam int c_LINES   = 4;
    localparam int c_CW      = 8;
    localparam int c_STATE_W = 3;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_S_IDLE   = 3'd0;
    localparam state_t c_S_LOOKUP = 3'd1;
    localparam state_t c_S_FILL   = 3'd2;
    localparam state_t c_S_WRITE  = 3'd3;
    localparam state_t c_S_RESP   = 3'd4;
endpackage
`default_nettype wire

// File: rtl/cache_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cache_ctrl_if : CPU load/store port, RAM port and statistics     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface cache_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 8
) ();
    logic          cpu_req;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_flush;
    logic          cpu_ready;
    logic          cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_hit;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, cpu_flush, mem_rdata, mem_ack,
        output cpu_ready, cpu_done, cpu_rdata, cpu_hit,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata, cpu_flush, mem_rdata, mem_ack,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_hit,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_line_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cache_line_array : fully associative {valid,tag,data} line store |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module cache_line_array
    import cache_ctrl_pkg::*;
#(
    parameter  int AW    = c_AW,
    parameter  int DW    = c_DW,
    parameter  int LINES = c_LINES,
    localparam int IW    = $clog2(LINES)
) (
    input  wire logic          clk,
    input  wire logic          clr,
    input  wire logic          i_flush,
    input  wire logic [AW-1:0] i_lookup_tag,
    output logic               o_match,
    output logic [IW-1:0]      o_hit_idx,
    output logic [DW-1:0]      o_hit_data,
    input  wire logic          i_we,
    input  wire logic          i_set_valid,
    input  wire logic [IW-1:0] i_w_idx,
    input  wire logic [AW-1:0] i_w_tag,
    input  wire logic [DW-1:0] i_w_data
);
    logic [LINES-1:0] r_valid;
    logic [AW-1:0]    r_tag  [LINES];
    logic [DW-1:0]    r_data [LINES];
    logic [LINES-1:0] w_line_hit;

    generate
        for (genvar g = 0; g < LINES; g++) begin : g_line
            assign w_line_hit[g] = r_valid[g] && (r_tag[g] == i_lookup_tag);
        end
    endgenerate

    // Tags are unique among valid lines, so at most one bit of w_line_hit is set.
    always_comb begin
        o_match    = 1'b0;
        o_hit_idx  = '0;
        o_hit_data = '0;
        for (int i = 0; i < LINES; i++) begin
            if (w_line_hit[i]) begin
                o_match    = 1'b1;
                o_hit_idx  = IW'(i);
                o_hit_data = r_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_tag[i_w_idx]  <= i_w_tag;
            r_data[i_w_idx] <= i_w_data;
            if (i_set_valid) begin
                r_valid[i_w_idx] <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cache_ctrl : sequencing FSM for a small write-through cache      |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int AW    = c_AW,
    parameter int DW    = c_DW,
    parameter int LINES = c_LINES,
    parameter int CW    = c_CW
) (
    input wire logic   clk,
    input wire logic   clr,
    cache_ctrl_if.slave bus
);
    localparam int c_IW = $clog2(LINES);

    state_t          r_state;
    logic            r_rw;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_hit;
    logic [c_IW-1:0] r_hit_idx;
    logic [c_IW-1:0] r_rr_ptr;
    logic [CW-1:0]   r_hit_cnt;
    logic [CW-1:0]   r_miss_cnt;
    logic            r_ready;
    logic            r_done;
    logic [DW-1:0]   r_rdata;
    logic            r_cpu_hit;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_ack_seen;
    logic [DW-1:0]   r_mem_data;

    logic            w_match;
    logic [c_IW-1:0] w_hit_idx;
    logic [DW-1:0]   w_hit_data;
    logic            w_is_fill;
    logic            w_we;

    // The RAM ack is registered first; the line update and response follow a cycle later.
    assign w_is_fill = (r_state == c_S_FILL);
    assign w_we      = r_ack_seen && (w_is_fill || ((r_state == c_S_WRITE) && r_hit));

    cache_line_array #(.AW(AW), .DW(DW), .LINES(LINES)) u_lines (
        .clk          (clk),
        .clr          (clr),
        .i_flush      ((r_state == c_S_IDLE) && bus.cpu_flush),
        .i_lookup_tag (r_addr),
        .o_match      (w_match),
        .o_hit_idx    (w_hit_idx),
        .o_hit_data   (w_hit_data),
        .i_we         (w_we),
        .i_set_valid  (w_is_fill),
        .i_w_idx      (w_is_fill ? r_rr_ptr : r_hit_idx),
        .i_w_tag      (r_addr),
        .i_w_data     (w_is_fill ? r_mem_data : r_wdata)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= c_S_IDLE;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            r_rr_ptr    <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_cpu_hit   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ack_seen  <= 1'b0;
            r_mem_data  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.cpu_flush) begin
                        r_rr_ptr <= '0;
                    end else if (bus.cpu_req) begin
                        r_rw    <= bus.cpu_rw;
                        r_addr  <= bus.cpu_addr;
                        r_wdata <= bus.cpu_wdata;
                        r_ready <= 1'b0;
                        r_state <= c_S_LOOKUP;
                    end
                end
                c_S_LOOKUP: begin
                    r_hit     <= w_match;
                    r_hit_idx <= w_hit_idx;
                    if (w_match) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                    if (r_rw) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= c_S_WRITE;
                    end else if (w_match) begin
                        r_rdata   <= w_hit_data;
                        r_cpu_hit <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= c_S_RESP;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                        r_state    <= c_S_FILL;
                    end
                end
                c_S_FILL, c_S_WRITE: begin
                    if (r_ack_seen) begin
                        r_ack_seen <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hit  <= r_hit;
                        if (w_is_fill) begin
                            r_rdata  <= r_mem_data;
                            r_rr_ptr <= r_rr_ptr + 1'b1;
                        end
                        r_state <= c_S_RESP;
                    end else if (bus.mem_ack) begin
                        r_ack_seen <= 1'b1;
                        r_mem_data <= bus.mem_rdata;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                    end
                end
                c_S_RESP: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = r_ready;
    assign bus.cpu_done  = r_done;
    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_hit   = r_cpu_hit;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.miss_cnt  = r_miss_cnt;
endmodule
`default_nettype wire
